// File: rtl/user_mgr_obi_arbiter_pkg.sv
// OBI request/response types and requester index type for the user-domain manager arbiter.
package user_mgr_obi_arbiter_pkg;

  localparam int unsigned UserMgrArbNumMgr = 2;

  typedef logic [$clog2(UserMgrArbNumMgr)-1:0] user_mgr_idx_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  aid;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  rid;
  } mgr_obi_r_t;

  typedef struct packed {
    logic       gnt;
    logic       rvalid;
    mgr_obi_r_t r;
  } mgr_obi_rsp_t;

  function automatic user_mgr_idx_t idx_inc(input user_mgr_idx_t idx);
    if (idx == user_mgr_idx_t'(UserMgrArbNumMgr - 1)) return '0;
    return idx + user_mgr_idx_t'(1);
  endfunction

endpackage

// File: rtl/user_mgr_obi_arb_idx_fifo.sv
// In-order FIFO of granted requester indices; push and pop may coincide even when full or empty.
module user_mgr_obi_arb_idx_fifo
  import user_mgr_obi_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          testmode_i,
  input  logic          push_i,
  input  user_mgr_idx_t data_i,
  input  logic          pop_i,
  output user_mgr_idx_t data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = Depth[PtrW:0];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  user_mgr_idx_t   mem_q [Depth];
  logic            do_push, do_pop;
  logic            unused_testmode;

  assign unused_testmode = testmode_i;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/user_mgr_obi_arbiter.sv
// Round-robin arbiter sharing one OBI manager port with in-order response routing and a credit limit.
// Build option: define USER_MGR_OBI_ARB_PRIO0_EN to give requester 0 fixed priority when unlocked.
module user_mgr_obi_arbiter
  import user_mgr_obi_arbiter_pkg::*;
#(
  parameter int unsigned NumMgr   = UserMgrArbNumMgr,
  parameter int unsigned MaxTrans = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         testmode_i,
  input  mgr_obi_req_t sbr_req_i [NumMgr],
  output mgr_obi_rsp_t sbr_rsp_o [NumMgr],
  output mgr_obi_req_t mgr_req_o,
  input  mgr_obi_rsp_t mgr_rsp_i,
  output logic         busy_o,
  output logic         err_o
);

  localparam int unsigned CntW = $clog2(MaxTrans) + 1;

  user_mgr_idx_t   rr_ptr_q, lock_idx_q, rr_winner, winner, cand, fifo_head;
  logic            lock_q, rr_found, req_valid, gnt_fire, rsp_fire;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] outstanding_q;

  always_comb begin
    rr_winner = rr_ptr_q;
    rr_found  = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NumMgr; i++) begin
      cand = user_mgr_idx_t'((32'(rr_ptr_q) + i) % NumMgr);
      if (!rr_found && sbr_req_i[cand].req) begin
        rr_winner = cand;
        rr_found  = 1'b1;
      end
    end
  end

  // A request that is out but not yet granted must stay on the same requester.
  always_comb begin
    if (lock_q) winner = lock_idx_q;
`ifdef USER_MGR_OBI_ARB_PRIO0_EN
    else if (sbr_req_i[0].req) winner = '0;
`endif
    else winner = rr_winner;
  end

  // Reset gating keeps the port quiet while upstream is still held in reset.
  assign rsp_fire  = mgr_rsp_i.rvalid && !fifo_empty;
  assign req_valid = rst_ni && sbr_req_i[winner].req && (!fifo_full || rsp_fire);
  assign gnt_fire  = req_valid && mgr_rsp_i.gnt;
  assign busy_o    = (outstanding_q != '0);

  always_comb begin
    mgr_req_o     = sbr_req_i[winner];
    mgr_req_o.req = req_valid;
    for (int unsigned i = 0; i < NumMgr; i++) begin
      sbr_rsp_o[i].gnt    = gnt_fire && (winner == user_mgr_idx_t'(i));
      sbr_rsp_o[i].rvalid = rsp_fire && (fifo_head == user_mgr_idx_t'(i));
      sbr_rsp_o[i].r      = mgr_rsp_i.r;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q      <= '0;
      lock_q        <= 1'b0;
      lock_idx_q    <= '0;
      outstanding_q <= '0;
      err_o         <= 1'b0;
    end else begin
      lock_q     <= req_valid && !gnt_fire;
      lock_idx_q <= winner;
      if (gnt_fire) begin
`ifdef USER_MGR_OBI_ARB_PRIO0_EN
        if (winner != '0) rr_ptr_q <= idx_inc(winner);
`else
        rr_ptr_q <= idx_inc(winner);
`endif
      end
      case ({gnt_fire, rsp_fire})
        2'b10:   outstanding_q <= outstanding_q + CntW'(1);
        2'b01:   outstanding_q <= outstanding_q - CntW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      if (mgr_rsp_i.rvalid && fifo_empty) err_o <= 1'b1;
    end
  end

  user_mgr_obi_arb_idx_fifo #(
    .Depth(MaxTrans)
  ) u_idx_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .testmode_i(testmode_i),
    .push_i    (gnt_fire),
    .data_i    (winner),
    .pop_i     (rsp_fire),
    .data_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_user_mgr_obi_arbiter.sv
// Directed bench for user_mgr_obi_arbiter; expected response routing is tracked in a scoreboard queue.
module tb_user_mgr_obi_arbiter;
  import user_mgr_obi_arbiter_pkg::*;

  localparam int unsigned NumMgr   = 2;
  localparam int unsigned MaxTrans = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         testmode_i;
  mgr_obi_req_t sbr_req [NumMgr];
  mgr_obi_rsp_t sbr_rsp [NumMgr];
  mgr_obi_req_t mgr_req;
  mgr_obi_rsp_t mgr_rsp;
  logic         busy, err;

  int vectors     = 0;
  int miscompares = 0;
  int sb[$];

  always #5 clk_i = ~clk_i;

  user_mgr_obi_arbiter #(
    .NumMgr  (NumMgr),
    .MaxTrans(MaxTrans)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .testmode_i(testmode_i),
    .sbr_req_i (sbr_req),
    .sbr_rsp_o (sbr_rsp),
    .mgr_req_o (mgr_req),
    .mgr_rsp_i (mgr_rsp),
    .busy_o    (busy),
    .err_o     (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] gnt_vec();
    return {sbr_rsp[1].gnt, sbr_rsp[0].gnt};
  endfunction

  function automatic logic [1:0] rv_vec();
    return {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid};
  endfunction

  function automatic logic [31:0] exp_addr(input int idx);
    return (idx == 0) ? 32'h1000_0000 : 32'h2000_0000;
  endfunction

  task automatic set_req(input logic r0, input logic r1);
    sbr_req[0].req = r0;
    sbr_req[1].req = r1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_gnt(input string tag, input int idx);
    logic [1:0] e;
    e = 2'b01 << idx;
    check({tag, "_gnt"}, gnt_vec(), e);
    check({tag, "_addr"}, mgr_req.addr, exp_addr(idx));
    sb.push_back(idx);
  endtask

  task automatic expect_rsp(input string tag);
    logic [1:0] e;
    e = 2'b00;
    if (sb.size() != 0) e = 2'b01 << sb.pop_front();
    check(tag, rv_vec(), e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni     = 1'b0;
    testmode_i = 1'b0;
    mgr_rsp    = '0;
    sbr_req[0] = '0;
    sbr_req[1] = '0;
    sbr_req[0].addr = 32'h1000_0000;
    sbr_req[0].aid  = 2'd1;
    sbr_req[1].addr = 32'h2000_0000;
    sbr_req[1].aid  = 2'd2;
    set_req(1'b1, 1'b1);
    mgr_rsp.gnt = 1'b1;
    #3;
    check("rst_req", mgr_req.req, 1'b0);
    check("rst_gnt", gnt_vec(), 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk_i);
    set_req(1'b0, 1'b0);
    mgr_rsp = '0;
    rst_ni  = 1'b1;
    tick();

    // 1: both requesting, gnt every cycle, rvalid one cycle later
    set_req(1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) set_req(1'b0, 1'b0);
      mgr_rsp.gnt     = (c < 4);
      mgr_rsp.rvalid  = (c > 0);
      mgr_rsp.r.rdata = 32'hA000_0000 + 32'(c);
      @(negedge clk_i);
      if (c < 4) expect_gnt("t1", c % 2);
      if (c > 0) expect_rsp("t1_rvalid");
      if (c == 2) check("t1_rdata", sbr_rsp[1].r.rdata, 32'hA000_0002);
      tick();
    end
    mgr_rsp = '0;
    @(negedge clk_i);
    check("t1_idle", busy, 1'b0);
    tick();

    // single grant to 0 so the pointer sits on 1 before the lock test
    set_req(1'b1, 1'b0);
    mgr_rsp.gnt = 1'b1;
    @(negedge clk_i);
    expect_gnt("t2_pre", 0);
    tick();
    set_req(1'b0, 1'b0);
    mgr_rsp.gnt    = 1'b0;
    mgr_rsp.rvalid = 1'b1;
    @(negedge clk_i);
    expect_rsp("t2_pre_rsp");
    tick();
    mgr_rsp.rvalid = 1'b0;

    // 2: gnt withheld three cycles, req1 rises while idx0 waits
    set_req(1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) sbr_req[1].req = 1'b1;
      @(negedge clk_i);
      check("t2_req", mgr_req.req, 1'b1);
      check("t2_addr", mgr_req.addr, exp_addr(0));
      check("t2_nognt", gnt_vec(), 2'b00);
      tick();
    end
    mgr_rsp.gnt = 1'b1;
    @(negedge clk_i);
    expect_gnt("t2_hold", 0);
    tick();
    sbr_req[0].req = 1'b0;
    @(negedge clk_i);
    expect_gnt("t2_next", 1);
    tick();
    set_req(1'b0, 1'b0);
    mgr_rsp.gnt    = 1'b0;
    mgr_rsp.rvalid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      expect_rsp("t2_rsp");
      tick();
    end
    mgr_rsp.rvalid = 1'b0;

    // 3: fill all credits, then bypass with a same-cycle rvalid
    set_req(1'b1, 1'b1);
    mgr_rsp.gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      expect_gnt("t3_fill", c % 2);
      tick();
    end
    @(negedge clk_i);
    check("t3_blocked_req", mgr_req.req, 1'b0);
    check("t3_blocked_gnt", gnt_vec(), 2'b00);
    check("t3_busy", busy, 1'b1);
    tick();
    mgr_rsp.rvalid = 1'b1;
    @(negedge clk_i);
    expect_rsp("t3_bypass_rsp");
    check("t3_bypass_req", mgr_req.req, 1'b1);
    expect_gnt("t3_bypass", 0);
    tick();
    set_req(1'b0, 1'b0);
    mgr_rsp.gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      expect_rsp("t3_drain");
      tick();
    end
    mgr_rsp.rvalid = 1'b0;
    @(negedge clk_i);
    check("t3_idle", busy, 1'b0);
    tick();

    // 4: stray rvalid with nothing outstanding
    mgr_rsp.rvalid = 1'b1;
    @(negedge clk_i);
    check("t4_no_rvalid", rv_vec(), 2'b00);
    check("t4_err_before", err, 1'b0);
    tick();
    mgr_rsp.rvalid = 1'b0;
    @(negedge clk_i);
    check("t4_err", err, 1'b1);
    tick();
    tick();
    @(negedge clk_i);
    check("t4_sticky", err, 1'b1);
    tick();

    // 5: asynchronous reset with three outstanding
    set_req(1'b1, 1'b0);
    mgr_rsp.gnt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      expect_gnt("t5_fill", 0);
      tick();
    end
    check("t5_busy_pre", busy, 1'b1);
    set_req(1'b1, 1'b1);
    mgr_rsp.rvalid = 1'b1;
    rst_ni = 1'b0;
    #1;
    check("t5_req", mgr_req.req, 1'b0);
    check("t5_gnt", gnt_vec(), 2'b00);
    check("t5_rvalid", rv_vec(), 2'b00);
    check("t5_busy", busy, 1'b0);
    check("t5_err", err, 1'b0);
    sb.delete();
    @(negedge clk_i);
    mgr_rsp.rvalid = 1'b0;
    rst_ni = 1'b1;
    #1;
    expect_gnt("t5_first", 0);
    tick();
    set_req(1'b0, 1'b0);
    mgr_rsp.gnt    = 1'b0;
    mgr_rsp.rvalid = 1'b1;
    @(negedge clk_i);
    expect_rsp("t5_rsp");
    tick();
    mgr_rsp.rvalid = 1'b0;

`ifdef USER_MGR_OBI_ARB_PRIO0_EN
    // 6: requester 0 priority with req0 toggling
    mgr_rsp.gnt = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_req((c % 2) == 0, 1'b1);
      mgr_rsp.rvalid = (c > 0);
      @(negedge clk_i);
      expect_gnt("t6", ((c % 2) == 0) ? 0 : 1);
      if (c > 0) expect_rsp("t6_rsp");
      tick();
    end
    set_req(1'b0, 1'b0);
    mgr_rsp.gnt    = 1'b0;
    mgr_rsp.rvalid = 1'b1;
    @(negedge clk_i);
    expect_rsp("t6_drain");
    tick();
    mgr_rsp.rvalid = 1'b0;
`endif

    @(negedge clk_i);
    check("end_idle", busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
